// File: rtl/uart_pkg.sv
// uart_pkg: FSM states, parity modes and data-length codes for uart_verici_gen
package uart_pkg;
  typedef enum logic [2:0] {BOSTA, BASLA, VER, PARITE, DUR, KIRMA} durum_t;
  localparam logic [1:0] PAR_YOK  = 2'd0;
  localparam logic [1:0] PAR_CIFT = 2'd1;
  localparam logic [1:0] PAR_TEK  = 2'd2;
  localparam logic [1:0] UZ_5 = 2'd0;
  localparam logic [1:0] UZ_6 = 2'd1;
  localparam logic [1:0] UZ_7 = 2'd2;
  localparam logic [1:0] UZ_8 = 2'd3;
  function automatic logic [2:0] son_idx(input logic [1:0] uz);
    return 3'd4 + {1'b0, uz};
  endfunction
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO with full/empty/occupancy flags
module uart_fifo #(
  parameter int W = 8,
  parameter int D = 4,
  localparam int AW = $clog2(D)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_wr,
  input  logic         i_rd,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty,
  output logic [AW:0]  o_count
);
  localparam logic [AW:0] DOLU = (AW+1)'(D);
  logic [W-1:0] r_mem [D];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign o_full  = r_cnt == DOLU;
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rp];
  assign w_push  = i_wr && !o_full;
  assign w_pop   = i_rd && !o_empty;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_din;
  always_ff @(posedge clk)
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + AW'(w_push);
      r_rp  <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/uart_verici_gen.sv
// uart_verici_gen: buffered UART transmitter, 5-8 data bits, parity, 1/2 stop bits.
// Define UART_KIRMA_EN to enable the break (KIRMA) state driven by kirma_istek.
module uart_verici_gen
  import uart_pkg::*;
#(
  parameter int VERI_BIT = 8,
  parameter int FIFO_DERINLIK = 4,
  parameter int BOL_W = 16,
  localparam int CW = $clog2(FIFO_DERINLIK) + 1
) (
  input  logic                clk_g,
  input  logic                rst_g,
  input  logic [VERI_BIT-1:0] ver_veri,
  input  logic                ver_gecerli,
  input  logic [BOL_W-1:0]    baud_bolen,
  input  logic [1:0]          veri_uzunluk,
  input  logic [1:0]          parite_mod,
  input  logic                dur_iki,
  input  logic                kirma_istek,
  output logic                TX,
  output logic                hazir,
  output logic                bos,
  output logic [CW-1:0]       doluluk
);
  durum_t r_st, w_st;
  logic [BOL_W-1:0] r_cnt, w_cnt, r_bb;
  logic [2:0] r_idx, w_idx;
  logic [7:0] r_sh;
  logic [1:0] r_uz, r_par;
  logic r_d2, r_tx, w_tx, w_pop, w_lat, w_son, w_son_bit, w_par_var, w_parite;
  logic w_full, w_empty;
  logic [VERI_BIT-1:0] w_dout;
`ifndef UART_KIRMA_EN
  logic w_kirma_unused;
  assign w_kirma_unused = kirma_istek;
`endif
  uart_fifo #(.W(VERI_BIT), .D(FIFO_DERINLIK)) u_fifo (
    .clk(clk_g), .rst(rst_g), .i_wr(ver_gecerli), .i_rd(w_pop), .i_din(ver_veri),
    .o_dout(w_dout), .o_full(w_full), .o_empty(w_empty), .o_count(doluluk)
  );
  assign TX    = r_tx;
  assign hazir = !w_full;
  assign bos   = w_empty && r_st == BOSTA;
  assign w_son     = r_cnt == r_bb;
  assign w_son_bit = r_idx == son_idx(r_uz);
  assign w_par_var = r_par == PAR_CIFT || r_par == PAR_TEK;
  assign w_parite  = ^(r_sh & (8'hFF >> (2'd3 - r_uz))) ^ (r_par == PAR_TEK);
  // frame config is sampled whenever idle so the break timer also sees a stable divisor
  assign w_lat     = w_pop || r_st == BOSTA;
  always_comb begin
    w_st  = r_st;
    w_idx = r_idx;
    w_pop = 1'b0;
    w_cnt = (r_st == BOSTA || w_son) ? '0 : r_cnt + 1'b1;
    case (r_st)
      BOSTA: begin
`ifdef UART_KIRMA_EN
        if (kirma_istek) w_st = KIRMA;
        else
`endif
        if (!w_empty) begin
          w_pop = 1'b1;
          w_st  = BASLA;
        end
      end
      BASLA: w_st = w_son ? VER : BASLA;
      VER: if (w_son) begin
        w_idx = w_son_bit ? 3'd0 : r_idx + 3'd1;
        w_st  = !w_son_bit ? VER : w_par_var ? PARITE : DUR;
      end
      PARITE: w_st = w_son ? DUR : PARITE;
      DUR: if (w_son) begin
        w_idx = (r_d2 && r_idx == 3'd0) ? 3'd1 : 3'd0;
        if (!(r_d2 && r_idx == 3'd0)) begin
          w_pop = !w_empty;
          w_st  = w_empty ? BOSTA : BASLA;
        end
      end
`ifdef UART_KIRMA_EN
      KIRMA: begin
        w_idx = w_son ? 3'd1 : r_idx;
        if (!kirma_istek && (r_idx != 3'd0 || w_son)) begin
          w_idx = 3'd0;
          w_st  = BOSTA;
        end
      end
`endif
      default: w_st = BOSTA;
    endcase
    w_tx = (w_st == VER) ? r_sh[w_idx] : (w_st == PARITE) ? w_parite :
           !(w_st == BASLA || w_st == KIRMA);
  end
  always_ff @(posedge clk_g)
    if (rst_g) begin
      r_st  <= BOSTA;
      r_cnt <= '0;
      r_idx <= '0;
      r_sh  <= '0;
      r_bb  <= '0;
      r_uz  <= UZ_8;
      r_par <= PAR_YOK;
      r_d2  <= 1'b0;
      r_tx  <= 1'b1;
    end else begin
      r_st  <= w_st;
      r_cnt <= w_cnt;
      r_idx <= w_idx;
      r_tx  <= w_tx;
      if (w_lat) begin
        r_sh  <= 8'(w_dout);
        r_bb  <= baud_bolen;
        r_uz  <= veri_uzunluk;
        r_par <= parite_mod;
        r_d2  <= dur_iki;
      end
    end
endmodule

// File: tb/tb_uart_verici_gen.sv
// tb_uart_verici_gen: randomized and directed bench with a queue-based line model
module tb_uart_verici_gen;
  localparam int D = 4;
`ifdef UART_KIRMA_EN
  localparam bit KEN = 1'b1;
`else
  localparam bit KEN = 1'b0;
`endif
  logic clk_g = 1'b0, rst_g = 1'b1;
  logic [7:0] ver_veri = '0;
  logic ver_gecerli = 1'b0;
  logic [15:0] baud_bolen = 16'd15;
  logic [1:0] veri_uzunluk = 2'd3, parite_mod = 2'd0;
  logic dur_iki = 1'b0, kirma_istek = 1'b0;
  logic TX, hazir, bos;
  logic [2:0] doluluk;

  uart_verici_gen dut (
    .clk_g(clk_g), .rst_g(rst_g), .ver_veri(ver_veri), .ver_gecerli(ver_gecerli),
    .baud_bolen(baud_bolen), .veri_uzunluk(veri_uzunluk), .parite_mod(parite_mod),
    .dur_iki(dur_iki), .kirma_istek(kirma_istek), .TX(TX), .hazir(hazir), .bos(bos),
    .doluluk(doluluk)
  );

  always #5 clk_g = ~clk_g;

  int checks = 0, errors = 0;
  bit line_q[$];
  logic [7:0] fq[$];
  logic tx_m = 1'b1;
  bit inf = 0, kir = 0;
  int kj = 0, kb = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // whole frame expanded into per-cycle line levels from the current settings
  task automatic build(input logic [7:0] w);
    bit lv[$];
    int n, ones;
    n = int'(veri_uzunluk) + 5;
    ones = 0;
    lv.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      lv.push_back(w[i]);
      ones += int'(w[i]);
    end
    if (parite_mod == 2'd1) lv.push_back(ones % 2 == 1);
    if (parite_mod == 2'd2) lv.push_back(ones % 2 == 0);
    lv.push_back(1'b1);
    if (dur_iki) lv.push_back(1'b1);
    foreach (lv[i]) repeat (int'(baud_bolen) + 1) line_q.push_back(lv[i]);
  endtask

  task automatic model();
    bit full_b;
    if (rst_g) begin
      line_q.delete();
      fq.delete();
      tx_m = 1'b1;
      inf = 0;
      kir = 0;
      return;
    end
    full_b = fq.size() == D;
    if (kir) begin
      kj++;
      if (!kirma_istek && kj >= kb + 1) begin
        kir = 0;
        tx_m = 1'b1;
      end
    end else if (line_q.size() > 0) tx_m = line_q.pop_front();
    else if (!inf && KEN && kirma_istek) begin
      kir = 1;
      kj = 0;
      kb = int'(baud_bolen);
      tx_m = 1'b0;
    end else if (fq.size() > 0) begin
      build(fq.pop_front());
      tx_m = line_q.pop_front();
      inf = 1;
    end else begin
      tx_m = 1'b1;
      inf = 0;
    end
    if (ver_gecerli && !full_b) fq.push_back(ver_veri);
  endtask

  task automatic tick();
    @(posedge clk_g);
    model();
    #1;
    chk("tx", TX, tx_m);
    chk("hazir", hazir, fq.size() < D);
    chk("doluluk", doluluk, fq.size());
    chk("bos", bos, fq.size() == 0 && !inf && !kir);
  endtask

  task automatic cfg(input int bb, input logic [1:0] uz, input logic [1:0] pm, input logic d2);
    baud_bolen = 16'(bb);
    veri_uzunluk = uz;
    parite_mod = pm;
    dur_iki = d2;
  endtask

  // push one word at bit time 16 and check mid-bit levels against a literal level vector
  task automatic frame_lit(input string nm, input logic [7:0] w, input logic [11:0] lv, input int nl);
    ver_veri = w;
    ver_gecerli = 1'b1;
    tick();
    ver_gecerli = 1'b0;
    chk({nm, "_bos_busy"}, bos, 1'b0);
    for (int e = 1; e <= nl * 16 + 1; e++) begin
      tick();
      if ((e - 1) % 16 == 8) chk({nm, "_lvl"}, TX, lv[(e-1)/16]);
      if (e == nl * 16) chk({nm, "_bos_last"}, bos, 1'b0);
    end
    chk({nm, "_bos_end"}, bos, 1'b1);
  endtask

  initial begin
    repeat (3) tick();
    rst_g = 1'b0;
    tick();
    chk("rst_tx", TX, 1'b1);
    chk("rst_hazir", hazir, 1'b1);
    chk("rst_bos", bos, 1'b1);
    chk("rst_doluluk", doluluk, 3'd0);

    cfg(15, 2'd3, 2'd0, 1'b0);
    frame_lit("8n1_55", 8'h55, 12'h2AA, 10);
    cfg(15, 2'd3, 2'd1, 1'b0);
    frame_lit("8e1_07", 8'h07, 12'h60E, 11);
    cfg(15, 2'd2, 2'd2, 1'b1);
    frame_lit("7o2_00", 8'h00, 12'h700, 11);

    cfg(15, 2'd3, 2'd0, 1'b0);
    ver_gecerli = 1'b1;
    for (int i = 0; i < 15; i++) begin
      ver_veri = (i < 5) ? 8'(8'hA1 + i) : 8'hEE;
      tick();
      if (i < 4) chk("fill_hazir", hazir, 1'b1);
      if (i == 1) chk("fill_cnt1", doluluk, 3'd1);
      if (i >= 4) chk("fill_full", hazir, 1'b0);
      if (i >= 4) chk("fill_cnt4", doluluk, 3'd4);
    end
    ver_gecerli = 1'b0;
    repeat (820) tick();
    chk("fill_drained", bos, 1'b1);

    ver_veri = 8'h3C;
    ver_gecerli = 1'b1;
    tick();
    ver_veri = 8'h01;
    for (int e = 1; e <= 180; e++) begin
      ver_gecerli = 1'b0;
      if (e == 40) begin
        baud_bolen = 16'd7;
        ver_gecerli = 1'b1;
      end
      tick();
      if (e == 161) chk("baud_start2", TX, 1'b0);
      if (e == 169) chk("baud_bit0", TX, 1'b1);
      if (e == 177) chk("baud_bit1", TX, 1'b0);
    end
    repeat (80) tick();

    cfg(15, 2'd3, 2'd0, 1'b0);
    ver_gecerli = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ver_veri = 8'(8'h90 + i);
      tick();
    end
    ver_gecerli = 1'b0;
    repeat (40) tick();
    rst_g = 1'b1;
    tick();
    rst_g = 1'b0;
    chk("mrst_tx", TX, 1'b1);
    chk("mrst_doluluk", doluluk, 3'd0);
    chk("mrst_bos", bos, 1'b1);
    repeat (200) tick();
    chk("mrst_quiet", TX, 1'b1);

`ifdef UART_KIRMA_EN
    kirma_istek = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      ver_veri = 8'h5A;
      ver_gecerli = (e == 10);
      tick();
      chk("kirma_low", TX, 1'b0);
    end
    ver_gecerli = 1'b0;
    kirma_istek = 1'b0;
    tick();
    chk("kirma_exit", TX, 1'b1);
    tick();
    chk("kirma_start", TX, 1'b0);
    repeat (170) tick();
`endif

    for (int c = 0; c < 6000; c++) begin
      ver_gecerli = ($urandom % 3) == 0;
      ver_veri = 8'($urandom);
      if ($urandom % 60 == 0)
        cfg(int'($urandom % 4), 2'($urandom), 2'($urandom), 1'($urandom));
      if ($urandom % 50 == 0) kirma_istek = ~kirma_istek;
      rst_g = ($urandom % 700) == 0;
      tick();
    end
    rst_g = 1'b0;
    ver_gecerli = 1'b0;
    kirma_istek = 1'b0;
    repeat (200) tick();
    chk("final_idle", bos, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
